// File: rtl/risc_core_p.sv
// risc_core_p: multi-cycle core (WAIT/DECODE/GET_A/GET_B/EXEC/WRITE) with an 8-entry register file.
// Define RISC_CORE_PREFETCH_EN to add a one-entry pending-instruction slot filled by load outside WAIT.
module risc_core_p #(
    parameter int DATA_W       = 16,
    parameter int RST_CLR_REGS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              err
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WRITE} state_t;

    state_t state_reg, state_next;

    logic [15:0]       ir_reg;
    logic [DATA_W-1:0] a_reg, b_reg, c_reg, out_reg;
    logic              n_reg, v_reg, z_reg, err_reg;
    logic [DATA_W-1:0] rf [8];

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic [7:0] imm8;

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign sh     = ir_reg[4:3];
    assign rm     = ir_reg[2:0];
    assign imm8   = ir_reg[7:0];

    logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn, is_undef;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_add     = (opcode == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_and     = (opcode == 3'b101) && (op == 2'b10);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_undef   = !(is_mov_imm || is_mov_reg || is_add || is_cmp || is_and || is_mvn);

    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = {{(DATA_W-8){imm8[7]}}, imm8};

    // Shifter sits on operand B only, between the B latch and the ALU
    logic [DATA_W-1:0] b_sh;
    always_comb begin
        b_sh = b_reg;
        case (sh)
            2'b01:   b_sh = {b_reg[DATA_W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_reg[DATA_W-1:1]};
            2'b11:   b_sh = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
            default: b_sh = b_reg;
        endcase
    end

    logic [DATA_W-1:0] sum, diff, alu;
    logic              diff_ovf;

    assign sum      = a_reg + b_sh;
    assign diff     = a_reg - b_sh;
    assign diff_ovf = (a_reg[DATA_W-1] != b_sh[DATA_W-1]) && (diff[DATA_W-1] != a_reg[DATA_W-1]);

    always_comb begin
        alu = b_sh;
        if (is_add)
            alu = sum;
        else if (is_and)
            alu = a_reg & b_sh;
        else if (is_mvn)
            alu = ~b_sh;
        else if (is_cmp)
            alu = diff;
    end

    logic start_go;

`ifdef RISC_CORE_PREFETCH_EN
    logic [15:0] pend_reg;
    logic        pend_valid_reg;

    assign start_go = s || pend_valid_reg;

    // The slot is consumed (or simply stays empty) on every edge spent in WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
        end else if (state_reg != WAIT) begin
            if (load) begin
                pend_reg       <= in;
                pend_valid_reg <= 1'b1;
            end
        end else begin
            pend_valid_reg <= 1'b0;
        end
    end
`else
    assign start_go = s;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT:    if (start_go) state_next = DECODE;
            DECODE: begin
                if (is_undef)
                    state_next = WAIT;
                else if (is_mov_imm)
                    state_next = WRITE;
                else if (is_mov_reg || is_mvn)
                    state_next = GET_B;
                else
                    state_next = GET_A;
            end
            GET_A:   state_next = GET_B;
            GET_B:   state_next = EXEC;
            EXEC:    state_next = is_cmp ? WAIT : WRITE;
            WRITE:   state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= WAIT;
            ir_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            out_reg   <= '0;
            n_reg     <= 1'b0;
            v_reg     <= 1'b0;
            z_reg     <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                WAIT: begin
`ifdef RISC_CORE_PREFETCH_EN
                    if (load)
                        ir_reg <= in;
                    else if (pend_valid_reg)
                        ir_reg <= pend_reg;
`else
                    if (load)
                        ir_reg <= in;
`endif
                end
                DECODE: if (is_undef) err_reg <= 1'b1;
                GET_A:  a_reg <= rf[rn];
                GET_B:  b_reg <= rf[rm];
                EXEC: begin
                    c_reg <= alu;
                    if (is_cmp) begin
                        n_reg <= diff[DATA_W-1];
                        z_reg <= (diff == '0);
                        v_reg <= diff_ovf;
                    end else begin
                        out_reg <= alu;
                    end
                end
                default: ;
            endcase
        end
    end

    logic              rf_we;
    logic [2:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign rf_we   = (state_reg == WRITE);
    assign wr_idx  = is_mov_imm ? rn : rd;
    assign wr_data = is_mov_imm ? imm_ext : c_reg;

    // Reset forces WAIT asynchronously, so an interrupted instruction can never reach WRITE
    for (genvar gi = 0; gi < 8; gi++) begin : g_rf
        logic [DATA_W-1:0] q_reg;
        if (RST_CLR_REGS != 0) begin : g_clr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    q_reg <= '0;
                else if (rf_we && (wr_idx == 3'(gi)))
                    q_reg <= wr_data;
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (rf_we && (wr_idx == 3'(gi)))
                    q_reg <= wr_data;
            end
        end
        assign rf[gi] = q_reg;
    end

    assign out = out_reg;
    assign N   = n_reg;
    assign V   = v_reg;
    assign Z   = z_reg;
    assign w   = (state_reg == WAIT);
    assign err = err_reg;

endmodule

// File: tb/tb_risc_core_p.sv
// Scoreboard bench for risc_core_p: 16-bit and 32-bit instances, expectations queued at issue,
// checked by per-instance monitors each time w returns high.
module tb_risc_core_p;
    typedef struct {
        int          id;
        int          lat;
        int          start;
        bit          chk_out;
        logic [63:0] exp_out;
        bit          chk_f;
        logic [2:0]  nvz;
        bit          exp_err;
        logic [2:0]  ridx;
        logic [63:0] exp_reg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s16, load16, s32, load32;
    logic [15:0] in16, in32;
    logic [15:0] out16;
    logic [31:0] out32;
    logic        N16, V16, Z16, w16, err16;
    logic        N32, V32, Z32, w32, err32;

    risc_core_p #(.DATA_W(16), .RST_CLR_REGS(1)) dut (
        .clk(clk), .reset(reset), .s(s16), .load(load16), .in(in16),
        .out(out16), .N(N16), .V(V16), .Z(Z16), .w(w16), .err(err16)
    );

    risc_core_p #(.DATA_W(32), .RST_CLR_REGS(1)) dut32 (
        .clk(clk), .reset(reset), .s(s32), .load(load32), .in(in32),
        .out(out32), .N(N32), .V(V32), .Z(Z32), .w(w32), .err(err32)
    );

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q16[$];
    exp_t q32[$];
    exp_t m16, m32;
    logic w16_prev = 1'b1;
    logic w32_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input int lat, input bit chk_out, input logic [63:0] o,
                                input bit chk_f, input logic [2:0] nvz, input bit er,
                                input logic [2:0] ridx, input logic [63:0] rv);
        exp_t e;
        e.id = id; e.lat = lat; e.start = 0; e.chk_out = chk_out; e.exp_out = o;
        e.chk_f = chk_f; e.nvz = nvz; e.exp_err = er; e.ridx = ridx; e.exp_reg = rv;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && w16 && !w16_prev) begin
            if (q16.size() == 0) begin
                check("q16_unexpected_idle", 64'(q16.size()), 64'd1);
            end else begin
                m16 = q16.pop_front();
                $display("txn16 %0d: out=%h nvz=%b err=%b lat=%0d R%0d=%h", m16.id, out16,
                         {N16, V16, Z16}, err16, cyc - m16.start, m16.ridx, dut.rf[m16.ridx]);
                check($sformatf("t%0d_lat", m16.id), 64'(cyc - m16.start), 64'(m16.lat));
                if (m16.chk_out) check($sformatf("t%0d_out", m16.id), 64'(out16), m16.exp_out);
                if (m16.chk_f) check($sformatf("t%0d_nvz", m16.id), 64'({N16, V16, Z16}), 64'(m16.nvz));
                check($sformatf("t%0d_err", m16.id), 64'(err16), 64'(m16.exp_err));
                check($sformatf("t%0d_reg", m16.id), 64'(dut.rf[m16.ridx]), m16.exp_reg);
            end
        end
        w16_prev = w16;
    end

    always @(negedge clk) begin
        if (reset && w32 && !w32_prev) begin
            if (q32.size() == 0) begin
                check("q32_unexpected_idle", 64'(q32.size()), 64'd1);
            end else begin
                m32 = q32.pop_front();
                $display("txn32 %0d: out=%h nvz=%b err=%b lat=%0d R%0d=%h", m32.id, out32,
                         {N32, V32, Z32}, err32, cyc - m32.start, m32.ridx, dut32.rf[m32.ridx]);
                check($sformatf("t%0d_lat", m32.id), 64'(cyc - m32.start), 64'(m32.lat));
                if (m32.chk_out) check($sformatf("t%0d_out", m32.id), 64'(out32), m32.exp_out);
                if (m32.chk_f) check($sformatf("t%0d_nvz", m32.id), 64'({N32, V32, Z32}), 64'(m32.nvz));
                check($sformatf("t%0d_err", m32.id), 64'(err32), 64'(m32.exp_err));
                check($sformatf("t%0d_reg", m32.id), 64'(dut32.rf[m32.ridx]), m32.exp_reg);
            end
        end
        w32_prev = w32;
    end

    task automatic wait_idle(input bit wide);
        int k;
        k = 0;
        while (((wide ? w32 : w16) == 1'b0) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        check(wide ? "idle32_timeout" : "idle16_timeout", 64'(wide ? w32 : w16), 64'd1);
        @(negedge clk);
    endtask

    task automatic issue(input bit wide, input logic [15:0] ins, input exp_t e);
        @(negedge clk);
        e.start = cyc + 1;
        if (wide) begin
            q32.push_back(e);
            in32 = ins; load32 = 1'b1; s32 = 1'b1;
        end else begin
            q16.push_back(e);
            in16 = ins; load16 = 1'b1; s16 = 1'b1;
        end
        @(posedge clk);
        #1;
        load16 = 1'b0; s16 = 1'b0; load32 = 1'b0; s32 = 1'b0;
        wait_idle(wide);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        s16 = 1'b0; load16 = 1'b0; in16 = '0;
        s32 = 1'b0; load32 = 1'b0; in32 = '0;
        repeat (3) @(negedge clk);
        check("rst_w", 64'(w16), 64'd1);
        check("rst_out", 64'(out16), 64'd0);
        check("rst_nvz", 64'({N16, V16, Z16}), 64'd0);
        check("rst_err", 64'(err16), 64'd0);
        reset = 1'b1;

        // id, lat, chk_out, out, chk_f, nvz, err, reg, value
        issue(0, 16'hD007, mk(1,  2, 0, 0,        1, 3'b000, 0, 3'd0, 64'h0007));
        issue(0, 16'hD102, mk(2,  2, 0, 0,        1, 3'b000, 0, 3'd1, 64'h0002));
        issue(0, 16'hA148, mk(3,  5, 1, 64'h0010, 1, 3'b000, 0, 3'd2, 64'h0010));
        issue(0, 16'hA83F, mk(4,  4, 0, 0,        1, 3'b000, 0, 3'd1, 64'h0002));
        issue(0, 16'hD707, mk(5,  2, 0, 0,        1, 3'b000, 0, 3'd7, 64'h0007));
        issue(0, 16'hA807, mk(6,  4, 0, 0,        1, 3'b001, 0, 3'd0, 64'h0007));
        issue(0, 16'hB861, mk(7,  4, 1, 64'hFFFD, 1, 3'b001, 0, 3'd3, 64'hFFFD));
        issue(0, 16'hB392, mk(8,  5, 1, 64'h0008, 1, 3'b001, 0, 3'd4, 64'h0008));
        issue(0, 16'hC0AB, mk(9,  4, 1, 64'hFFFA, 1, 3'b001, 0, 3'd5, 64'hFFFA));
        issue(0, 16'hD6FF, mk(10, 2, 0, 0,        1, 3'b001, 0, 3'd6, 64'hFFFF));
        issue(0, 16'hC0D6, mk(11, 4, 1, 64'h7FFF, 1, 3'b001, 0, 3'd6, 64'h7FFF));
        issue(0, 16'hAE03, mk(12, 4, 0, 0,        1, 3'b110, 0, 3'd6, 64'h7FFF));
        issue(0, 16'hA121, mk(13, 5, 1, 64'h0004, 1, 3'b110, 0, 3'd1, 64'h0004));
        issue(0, 16'h0000, mk(14, 1, 1, 64'h0004, 1, 3'b110, 1, 3'd1, 64'h0004));

        issue(1, 16'hD1FF, mk(15, 2, 1, 0, 1, 3'b000, 0, 3'd1, 64'hFFFF_FFFF));
        issue(1, 16'hE000, mk(16, 1, 1, 0, 1, 3'b000, 1, 3'd1, 64'hFFFF_FFFF));
        check("w32_err_sticky", 64'(err32), 64'd1);

        // Abort an ADD in GET_B with an asynchronous reset
        @(negedge clk);
        in16 = 16'hA148; load16 = 1'b1; s16 = 1'b1;
        @(posedge clk);
        #1;
        load16 = 1'b0; s16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_busy", 64'(w16), 64'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_w", 64'(w16), 64'd1);
        check("mid_rst_out", 64'(out16), 64'd0);
        check("mid_rst_nvz", 64'({N16, V16, Z16}), 64'd0);
        check("mid_rst_err", 64'(err16), 64'd0);
        check("mid_rst_ir", 64'(dut.ir_reg), 64'd0);
        check("mid_rst_r1", 64'(dut.rf[1]), 64'd0);
        check("mid_rst_err32", 64'(err32), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_r2_after", 64'(dut.rf[2]), 64'd0);

        issue(0, 16'hD007, mk(20, 2, 0, 0, 1, 3'b000, 0, 3'd0, 64'h0007));

`ifdef RISC_CORE_PREFETCH_EN
        begin
            exp_t e;
            int   st;
            @(negedge clk);
            st = cyc + 1;
            e = mk(21, 5, 1, 64'h000E, 1, 3'b000, 0, 3'd2, 64'h000E);
            e.start = st;
            q16.push_back(e);
            e = mk(22, 2, 1, 64'h000E, 1, 3'b000, 0, 3'd0, 64'h0003);
            e.start = st + 6;
            q16.push_back(e);
            in16 = 16'hA148; load16 = 1'b1; s16 = 1'b1;
            @(posedge clk);
            #1;
            load16 = 1'b0; s16 = 1'b0;
            @(negedge clk);
            in16 = 16'hD003; load16 = 1'b1;
            @(negedge clk);
            load16 = 1'b0;
            repeat (12) @(negedge clk);
            check("pf_idle", 64'(w16), 64'd1);
        end
`endif

        check("q16_drain", 64'(q16.size()), 64'd0);
        check("q32_drain", 64'(q32.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_core_p.md
RISC_CORE_P -- requirements
Module: risc_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath and register width (legal range 16..64).
REQ-002 SHALL have parameter RST_CLR_REGS, default 1, meaning 1 clears R0-R7 on reset and 0 leaves them unchanged.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (rising edge).
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port s, input, 1, meaning start execution of the held instruction.
REQ-006 SHALL have port load, input, 1, meaning capture in into the instruction register.
REQ-007 SHALL have port in, input, 16, meaning instruction word.
REQ-008 SHALL have port out, output, DATA_W, meaning last ALU result written to a register.
REQ-009 SHALL have ports N, V, Z, output, 1 each, meaning status flags (negative, signed overflow, zero).
REQ-010 SHALL have port w, output, 1, meaning core is idle and waiting in state WAIT.
REQ-011 SHALL have port err, output, 1, meaning sticky undefined-opcode flag.

Function
REQ-012 SHALL decode the 16-bit encoding: opcode in[15:13], op in[12:11], Rn in[10:8], Rd in[7:5], sh in[4:3], Rm in[2:0], imm8 in[7:0].
REQ-013 SHALL implement MOV Rn,#imm8 as 110/10, MOV Rd,Rm{sh} as 110/00, ADD as 101/00, CMP Rn,Rm{sh} as 101/01, AND as 101/10, and MVN Rd,Rm{sh} as 101/11; every other opcode/op pair is undefined.
REQ-014 SHALL sign-extend imm8 to DATA_W.
REQ-015 SHALL apply sh to operand B only: 00 passes it unchanged, 01 is LSL by 1, 10 is LSR by 1 with zero fill, 11 is ASR by 1.
REQ-016 SHALL run FSM states WAIT, DECODE, GET_A, GET_B, EXEC, WRITE, each lasting exactly one cycle; w=1 only in WAIT.
REQ-017 SHALL leave WAIT for DECODE on the edge where s=1; s is ignored outside WAIT.
REQ-018 SHALL follow these paths: MOV imm goes DECODE->WRITE; MOV reg and MVN go DECODE->GET_B->EXEC->WRITE; ADD and AND go DECODE->GET_A->GET_B->EXEC->WRITE; CMP goes DECODE->GET_A->GET_B->EXEC; every path then returns to WAIT.
REQ-019 SHALL write the register file on the edge leaving WRITE, and SHALL update out on the edge leaving EXEC.
REQ-020 SHALL update N, V and Z only on the edge leaving EXEC of CMP, from Rn-B: N=MSB, Z=(result==0), V=signed overflow; all other instructions leave the flags unchanged.
REQ-021 SHALL perform DATA_W-wide arithmetic with carry discarded.
REQ-022 SHALL latch in into the instruction register when load=1 while in WAIT; load=1 and s=1 on the same edge executes the newly loaded word.
REQ-023 SHALL handle an undefined opcode by setting err=1, going DECODE->WAIT, and changing no register, flag or out.
REQ-024 SHALL keep err set until reset.
REQ-025 SHALL support reads of Rn=Rd within one instruction, returning the pre-write value.

Reset
REQ-026 SHALL, with reset=0 at any time including mid-instruction, immediately force: state WAIT, w=1, out=0, N=V=Z=0, err=0, instruction register=0, pending slot empty.
REQ-027 SHALL clear R0-R7 on reset if RST_CLR_REGS=1.
REQ-028 SHALL abort an interrupted instruction with no partial write.

Configuration
REQ-029 SHALL, with RISC_CORE_PREFETCH_EN defined, capture load=1 outside WAIT into a one-entry pending slot; a later load overwrites it (last wins).
REQ-030 SHALL, with RISC_CORE_PREFETCH_EN defined, stay in WAIT for exactly one cycle (w pulses high for 1 cycle) when returning with the pending slot full, then move pending into IR, clear the slot, and enter DECODE without s.
REQ-031 SHALL, without RISC_CORE_PREFETCH_EN, ignore load outside WAIT and contain no pending slot logic.

Verification
REQ-032 SHALL cover, with DATA_W=16: 0xD007 (MOV R0,#7), s pulse -> R0=0x0007, w high 2 cycles after start.
REQ-033 SHALL cover, following REQ-032: 0xD102 (MOV R1,#2), then 0xA148 (ADD R2,R1,R0,LSL#1) -> R2=0x0010, out=0x0010, w high 5 cycles after start.
REQ-034 SHALL cover, following REQ-033: 0xA83F (CMP R0,R7,ASR#1) with R7=0 -> N=0, V=0, Z=0; then 0xA807 (CMP R0,R7) with R7=7 -> Z=1.
REQ-035 SHALL cover, with DATA_W=32: 0xD1FF -> R1=0xFFFFFFFF; then 0xE000 (undefined) -> err=1 and no register changes.
REQ-036 SHALL cover: reset asserted during GET_B of an ADD -> w=1 immediately and destination unchanged (0 if RST_CLR_REGS=1).
REQ-037 SHALL cover, with RISC_CORE_PREFETCH_EN: load 0xD003 during an ADD -> after the ADD, w=1 for 1 cycle, then R0=0x0003 with no s.
